// File: rtl/cv32e40p_ex_wb_arbiter_if.sv
// Result-source and register-file write-port bundle for cv32e40p_ex_wb_arbiter.
// slave: the arbiter side; master: the producer / register-file side.
interface cv32e40p_ex_wb_arbiter_if #(
    parameter int unsigned NUM_SRC   = 4,
    parameter int unsigned NUM_PORTS = 2,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 6
);
    logic [NUM_SRC-1:0]               src_valid_i;
    logic [NUM_SRC-1:0]               src_ready_o;
    logic [NUM_SRC-1:0][ADDR_W-1:0]   src_waddr_i;
    logic [NUM_SRC-1:0][DATA_W-1:0]   src_wdata_i;
    logic [NUM_PORTS-1:0]             wb_we_o;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] wb_waddr_o;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wb_wdata_o;

    modport slave (
        input  src_valid_i, src_waddr_i, src_wdata_i,
        output src_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o
    );

    modport master (
        output src_valid_i, src_waddr_i, src_wdata_i,
        input  src_ready_o, wb_we_o, wb_waddr_o, wb_wdata_o
    );
endinterface

// File: rtl/cv32e40p_ex_wb_arbiter.sv
// Writeback arbiter: NUM_SRC buffered result sources share NUM_PORTS
// register-file write ports. Each source has a FIFO_DEPTH-entry FIFO; a
// round-robin scan grants up to NUM_PORTS heads per cycle, skipping any head
// whose address matches one already granted this cycle.
// Optional stall counter: define CV32E40P_WB_PERF_CNT_EN to add perf_clr_i and
// perf_stall_cnt_o.
module cv32e40p_ex_wb_arbiter #(
    parameter int unsigned NUM_SRC    = 4,
    parameter int unsigned NUM_PORTS  = 2,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush_i,
    cv32e40p_ex_wb_arbiter_if.slave bus,
    output logic busy_o,
    output logic contention_o
`ifdef CV32E40P_WB_PERF_CNT_EN
    ,
    input  logic        perf_clr_i,
    output logic [31:0] perf_stall_cnt_o
`endif
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned RR_W  = $clog2(NUM_SRC);

    logic [PTR_W-1:0]  rd_ptr [NUM_SRC];
    logic [PTR_W-1:0]  wr_ptr [NUM_SRC];
    logic [CNT_W-1:0]  count  [NUM_SRC];
    logic [RR_W-1:0]   rr_ptr;
    logic [RR_W-1:0]   rr_next;

    logic [ADDR_W-1:0] mem_addr [NUM_SRC][FIFO_DEPTH];
    logic [DATA_W-1:0] mem_data [NUM_SRC][FIFO_DEPTH];
    logic [ADDR_W-1:0] head_addr [NUM_SRC];
    logic [DATA_W-1:0] head_data [NUM_SRC];

    logic [NUM_SRC-1:0] nonempty;
    logic [NUM_SRC-1:0] ready;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] grant;
    logic               contention;

    logic [NUM_PORTS-1:0]             port_we;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] port_data;

    // Per-source FIFO status, head entry and push acceptance
    always_comb begin
        nonempty = '0;
        ready    = '0;
        push     = '0;
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            head_addr[s] = mem_addr[s][rd_ptr[s]];
            head_data[s] = mem_data[s][rd_ptr[s]];
            nonempty[s]  = (count[s] != '0);
            ready[s]     = (count[s] != CNT_W'(FIFO_DEPTH));
            push[s]      = bus.src_valid_i[s] & ready[s] & ~flush_i;
        end
    end

    // Round-robin scan from rr_ptr; the k-th grant drives port k.
    // A head matching an address granted earlier in the scan is skipped so
    // same-register writes retire in scan order across cycles.
    always_comb begin
        int unsigned idx;
        int unsigned n_grant;
        logic        hazard;
        idx        = 0;
        n_grant    = 0;
        hazard     = 1'b0;
        grant      = '0;
        port_we    = '0;
        port_addr  = '0;
        port_data  = '0;
        contention = 1'b0;
        rr_next    = rr_ptr;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_SRC) begin
                idx = idx - NUM_SRC;
            end
            if (nonempty[idx]) begin
                hazard = 1'b0;
                for (int unsigned k = 0; k < NUM_PORTS; k++) begin
                    if (k < n_grant && port_addr[k] == head_addr[idx]) begin
                        hazard = 1'b1;
                    end
                end
                if (!flush_i && n_grant < NUM_PORTS && !hazard) begin
                    grant[idx]         = 1'b1;
                    port_we[n_grant]   = 1'b1;
                    port_addr[n_grant] = head_addr[idx];
                    port_data[n_grant] = head_data[idx];
                    n_grant            = n_grant + 1;
                    rr_next            = (idx + 1 == NUM_SRC) ? '0 : RR_W'(idx + 1);
                end else begin
                    contention = 1'b1;
                end
            end
        end
    end

    // FIFO pointers, occupancy and round-robin pointer; flush keeps rr_ptr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
            rr_ptr <= '0;
        end else if (flush_i) begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                rd_ptr[s] <= '0;
                wr_ptr[s] <= '0;
                count[s]  <= '0;
            end
        end else begin
            for (int unsigned s = 0; s < NUM_SRC; s++) begin
                if (push[s]) begin
                    wr_ptr[s] <= wr_ptr[s] + PTR_W'(1);
                end
                if (grant[s]) begin
                    rd_ptr[s] <= rd_ptr[s] + PTR_W'(1);
                end
                count[s] <= count[s] + CNT_W'(push[s]) - CNT_W'(grant[s]);
            end
            rr_ptr <= rr_next;
        end
    end

    // Entry storage, written only on an accepted push
    always_ff @(posedge clk) begin
        for (int unsigned s = 0; s < NUM_SRC; s++) begin
            if (push[s]) begin
                mem_addr[s][wr_ptr[s]] <= bus.src_waddr_i[s];
                mem_data[s][wr_ptr[s]] <= bus.src_wdata_i[s];
            end
        end
    end

`ifdef CV32E40P_WB_PERF_CNT_EN
    // Saturating count of cycles with an ungranted non-empty head
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_cnt_o <= '0;
        end else if (perf_clr_i) begin
            perf_stall_cnt_o <= '0;
        end else if (contention && perf_stall_cnt_o != '1) begin
            perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
        end
    end
`endif

    assign bus.src_ready_o = ready;
    assign bus.wb_we_o     = port_we;
    assign bus.wb_waddr_o  = port_addr;
    assign bus.wb_wdata_o  = port_data;
    assign busy_o          = |nonempty;
    assign contention_o    = contention;

endmodule

// File: tb/tb_cv32e40p_ex_wb_arbiter.sv
// Testbench for cv32e40p_ex_wb_arbiter (NUM_SRC=4, NUM_PORTS=2, DEPTH=2):
// directed vector table followed by randomized traffic against a queue model.
module tb_cv32e40p_ex_wb_arbiter;

    logic clk = 1'b0;
    logic rst_n;
    logic flush;
    logic busy;
    logic cont;
`ifdef CV32E40P_WB_PERF_CNT_EN
    logic        perf_clr;
    logic [31:0] perf_cnt;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    cv32e40p_ex_wb_arbiter_if #(
        .NUM_SRC(4), .NUM_PORTS(2), .DATA_W(32), .ADDR_W(6)
    ) bus ();

    cv32e40p_ex_wb_arbiter #(
        .NUM_SRC(4), .NUM_PORTS(2), .DATA_W(32), .ADDR_W(6), .FIFO_DEPTH(2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (flush),
        .bus          (bus),
        .busy_o       (busy),
        .contention_o (cont)
`ifdef CV32E40P_WB_PERF_CNT_EN
        ,
        .perf_clr_i       (perf_clr),
        .perf_stall_cnt_o (perf_cnt)
`endif
    );

    typedef struct {
        logic              flush;
        logic [3:0]        valid;
        logic [3:0][5:0]   waddr;
        logic [3:0][31:0]  wdata;
        logic [3:0]        e_ready;
        logic [1:0]        e_we;
        logic [1:0][5:0]   e_waddr;
        logic [1:0][31:0]  e_wdata;
        logic              e_busy;
        logic              e_cont;
    } vec_t;

    vec_t vecs[$];
    int   perf_idx;

    // register file image built from observed writes
    logic [31:0] rf [64];
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (bus.wb_we_o[k]) rf[bus.wb_waddr_o[k]] <= bus.wb_wdata_o[k];
            end
        end
    end

    // reference model state
    logic [5:0]       qa [4][$];
    logic [31:0]      qd [4][$];
    int unsigned      m_rr, m_nrr;
    logic [3:0]       m_ready, m_gnt;
    logic [1:0]       m_we;
    logic [1:0][5:0]  m_wa;
    logic [1:0][31:0] m_wd;
    logic             m_busy, m_cont;
    logic [31:0]      m_perf;

    function automatic void add_vec(input logic fl, input logic [3:0] v, input logic [23:0] wa,
                                    input logic [127:0] wd, input logic [3:0] er, input logic [1:0] ew,
                                    input logic [11:0] ewa, input logic [63:0] ewd, input logic eb,
                                    input logic ec);
        vec_t t;
        t.flush = fl; t.valid = v; t.waddr = wa; t.wdata = wd;
        t.e_ready = er; t.e_we = ew; t.e_waddr = ewa; t.e_wdata = ewd;
        t.e_busy = eb; t.e_cont = ec;
        vecs.push_back(t);
    endfunction

    function automatic void add_idle();
        add_vec(1'b0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b00, 12'h0, 64'h0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] er, input logic [1:0] ew,
                             input logic [11:0] ewa, input logic [63:0] ewd, input logic eb,
                             input logic ec);
        chk({tag, "_ready"}, 128'(bus.src_ready_o), 128'(er));
        chk({tag, "_we"},    128'(bus.wb_we_o),     128'(ew));
        chk({tag, "_waddr"}, 128'(bus.wb_waddr_o),  128'(ewa));
        chk({tag, "_wdata"}, 128'(bus.wb_wdata_o),  128'(ewd));
        chk({tag, "_busy"},  128'(busy),            128'(eb));
        chk({tag, "_cont"},  128'(cont),            128'(ec));
    endtask

    task automatic drive(input logic fl, input logic [3:0] v, input logic [23:0] wa,
                         input logic [127:0] wd);
        flush           = fl;
        bus.src_valid_i = v;
        bus.src_waddr_i = wa;
        bus.src_wdata_i = wd;
    endtask

    // expected outputs for the current cycle from queue contents
    function automatic void model_eval(input logic fl);
        int unsigned n;
        int unsigned s;
        logic        dup;
        n = 0; m_we = '0; m_wa = '0; m_wd = '0; m_gnt = '0;
        m_cont = 1'b0; m_busy = 1'b0; m_nrr = m_rr;
        for (int j = 0; j < 4; j++) begin
            m_ready[j] = (qa[j].size() < 2);
            if (qa[j].size() != 0) m_busy = 1'b1;
        end
        for (int i = 0; i < 4; i++) begin
            s = (m_rr + i) % 4;
            if (qa[s].size() != 0) begin
                dup = 1'b0;
                for (int k = 0; k < int'(n); k++) if (m_wa[k] == qa[s][0]) dup = 1'b1;
                if (!fl && n < 2 && !dup) begin
                    m_gnt[s] = 1'b1;
                    m_we[n]  = 1'b1;
                    m_wa[n]  = qa[s][0];
                    m_wd[n]  = qd[s][0];
                    n++;
                    m_nrr = (s + 1) % 4;
                end else begin
                    m_cont = 1'b1;
                end
            end
        end
    endfunction

    // state change at the next clock edge
    function automatic void model_step(input logic fl, input logic [3:0] v,
                                       input logic [3:0][5:0] wa, input logic [3:0][31:0] wd);
        logic acc;
        if (m_cont && m_perf != 32'hFFFF_FFFF) m_perf = m_perf + 1;
        if (fl) begin
            for (int j = 0; j < 4; j++) begin
                qa[j].delete();
                qd[j].delete();
            end
        end else begin
            for (int j = 0; j < 4; j++) begin
                acc = v[j] && (qa[j].size() < 2);
                if (m_gnt[j]) begin
                    void'(qa[j].pop_front());
                    void'(qd[j].pop_front());
                end
                if (acc) begin
                    qa[j].push_back(wa[j]);
                    qd[j].push_back(wd[j]);
                end
            end
            m_rr = m_nrr;
        end
    endfunction

    function automatic void model_reset();
        for (int j = 0; j < 4; j++) begin
            qa[j].delete();
            qd[j].delete();
        end
        m_rr = 0;
        m_perf = '0;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0]       rv;
        logic [3:0][5:0]  rwa;
        logic [3:0][31:0] rwd;
        logic             rfl;

        // idle after reset
        for (int i = 0; i < 10; i++) add_idle();
        // four sources, two ports
        add_vec(0, 4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, {32'h103, 32'h102, 32'h101, 32'h100},
                4'hF, 2'b00, 12'h0, 64'h0, 0, 0);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b11, {6'd2, 6'd1}, {32'h101, 32'h100}, 1, 1);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b11, {6'd4, 6'd3}, {32'h103, 32'h102}, 1, 0);
        add_idle();
        perf_idx = vecs.size() - 1;
        // single push from source 2
        add_vec(0, 4'b0100, {6'd0, 6'd5, 6'd0, 6'd0}, {32'd0, 32'hDEADBEEF, 32'd0, 32'd0},
                4'hF, 2'b00, 12'h0, 64'h0, 0, 0);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b01, {6'd0, 6'd5}, {32'd0, 32'hDEADBEEF}, 1, 0);
        add_idle();
        // scan must now start at source 3
        add_vec(0, 4'b1011, {6'd11, 6'd0, 6'd12, 6'd10}, {32'hB3, 32'h0, 32'hC1, 32'hA0},
                4'hF, 2'b00, 12'h0, 64'h0, 0, 0);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b11, {6'd10, 6'd11}, {32'hA0, 32'hB3}, 1, 1);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b01, {6'd0, 6'd12}, {32'h0, 32'hC1}, 1, 0);
        add_idle();
        // same-address hazard
        add_vec(0, 4'b0011, {6'd0, 6'd0, 6'd7, 6'd7}, {32'h0, 32'h0, 32'hBBBBBBBB, 32'hAAAAAAAA},
                4'hF, 2'b00, 12'h0, 64'h0, 0, 0);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b01, {6'd0, 6'd7}, {32'h0, 32'hAAAAAAAA}, 1, 1);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b01, {6'd0, 6'd7}, {32'h0, 32'hBBBBBBBB}, 1, 0);
        add_idle();
        // source 0 fills while hazards hold it back
        add_vec(0, 4'b1101, {6'd9, 6'd9, 6'd0, 6'd9}, {32'h33, 32'h22, 32'h0, 32'hA1},
                4'hF, 2'b00, 12'h0, 64'h0, 0, 0);
        add_vec(0, 4'b0001, {18'h0, 6'd9}, {96'h0, 32'hA2}, 4'hF, 2'b01, {6'd0, 6'd9}, {32'h0, 32'h22}, 1, 1);
        add_vec(0, 4'b0001, {18'h0, 6'd9}, {96'h0, 32'hA3}, 4'hE, 2'b01, {6'd0, 6'd9}, {32'h0, 32'h33}, 1, 1);
        add_vec(0, 4'b0001, {18'h0, 6'd9}, {96'h0, 32'hA4}, 4'hE, 2'b01, {6'd0, 6'd9}, {32'h0, 32'hA1}, 1, 0);
        add_vec(0, 4'b0001, {18'h0, 6'd9}, {96'h0, 32'hA5}, 4'hF, 2'b01, {6'd0, 6'd9}, {32'h0, 32'hA2}, 1, 0);
        add_vec(0, 4'h0, 24'h0, 128'h0, 4'hF, 2'b01, {6'd0, 6'd9}, {32'h0, 32'hA5}, 1, 0);
        add_idle();
        // flush with three FIFOs occupied and a simultaneous push
        add_vec(0, 4'b0111, {6'd0, 6'd22, 6'd21, 6'd20}, {32'h0, 32'hF2, 32'hF1, 32'hF0},
                4'hF, 2'b00, 12'h0, 64'h0, 0, 0);
        add_vec(1, 4'b1001, {6'd23, 6'd0, 6'd0, 6'd24}, {32'hF3, 32'h0, 32'h0, 32'hF4},
                4'hF, 2'b00, 12'h0, 64'h0, 1, 1);
        for (int i = 0; i < 3; i++) add_idle();

        rst_n = 1'b0;
        drive(0, 4'h0, 24'h0, 128'h0);
`ifdef CV32E40P_WB_PERF_CNT_EN
        perf_clr = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        check_all("in_reset", 4'hF, 2'b00, 12'h0, 64'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            drive(vecs[i].flush, vecs[i].valid, vecs[i].waddr, vecs[i].wdata);
            #3;
            check_all($sformatf("v%0d", i), vecs[i].e_ready, vecs[i].e_we, vecs[i].e_waddr,
                      vecs[i].e_wdata, vecs[i].e_busy, vecs[i].e_cont);
`ifdef CV32E40P_WB_PERF_CNT_EN
            if (i == perf_idx) chk("perf_after_4src", 128'(perf_cnt), 128'd1);
`endif
        end
        chk("rf7_final", 128'(rf[7]), 128'hBBBBBBBB);

`ifdef CV32E40P_WB_PERF_CNT_EN
        @(posedge clk);
        #1;
        drive(0, 4'h0, 24'h0, 128'h0);
        #3;
        chk("perf_total", 128'(perf_cnt), 128'd6);
        perf_clr = 1'b1;
        @(posedge clk);
        #1;
        perf_clr = 1'b0;
        #3;
        chk("perf_clear", 128'(perf_cnt), 128'd0);
`endif

        // randomized traffic against the queue model
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 400; cyc++) begin
            @(posedge clk);
            #1;
            rv  = 4'($urandom);
            rfl = ($urandom_range(0, 19) == 0);
            for (int j = 0; j < 4; j++) begin
                rwa[j] = 6'($urandom_range(0, 7));
                rwd[j] = $urandom;
            end
            drive(rfl, rv, rwa, rwd);
            model_eval(rfl);
            #3;
            check_all($sformatf("r%0d", cyc), m_ready, m_we, m_wa, m_wd, m_busy, m_cont);
`ifdef CV32E40P_WB_PERF_CNT_EN
            chk($sformatf("r%0d_perf", cyc), 128'(perf_cnt), 128'(m_perf));
`endif
            if (cyc == 200) begin
                // asynchronous reset in the middle of traffic
                drive(0, rv, rwa, rwd);
                #2;
                rst_n = 1'b0;
                #1;
                check_all("midrst", 4'hF, 2'b00, 12'h0, 64'h0, 1'b0, 1'b0);
`ifdef CV32E40P_WB_PERF_CNT_EN
                chk("midrst_perf", 128'(perf_cnt), 128'd0);
`endif
                model_reset();
                @(posedge clk);
                #2;
                drive(0, 4'h0, 24'h0, 128'h0);
                rst_n = 1'b1;
            end else begin
                model_step(rfl, rv, rwa, rwd);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
